// File: rtl/pin_entry_buffer.sv
// ---------------------------------------------------------------------------
// pin_entry_buffer
//   Keypad-side entry stage of the doorlock datapath. Captures up to four BCD
//   digits in entry order from debounced key events and presents them as four
//   parallel digits for the BCD-to-one-hot decode stage. Handles the clear
//   (*) and enter (#) keys and the DONE/ACK handshake with the comparator.
//
//   Optional feature macro: PIN_ENTRY_TIMEOUT_EN
//     defined   -> idle counter present; the buffer auto-clears after
//                  TIMEOUT_CYCLES idle cycles in ENTRY with digits held.
//     undefined -> no counter, TIMEOUT tied low, TIMEOUT_CYCLES unused.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous active-high reset
//   KEY_VALID  in   level, high while a debounced key is held
//   KEY_CODE   in   0-9 digit, 10 clear, 11 enter, 12-15 ignored
//   ACK        in   comparator consumed the PIN, releases DONE
//   D1..D4     out  entered digits in order, 4'hF when empty
//   COUNT      out  digits held, 0-4
//   FULL       out  COUNT==4
//   PIN_READY  out  one-cycle pulse when a complete PIN is committed
//   ENTRY_ERR  out  one-cycle pulse on enter with COUNT<4
//   TIMEOUT    out  one-cycle pulse on inactivity auto-clear
// ---------------------------------------------------------------------------
module pin_entry_buffer #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       KEY_VALID,
   input  logic [3:0] KEY_CODE,
   input  logic       ACK,
   output logic [3:0] D1,
   output logic [3:0] D2,
   output logic [3:0] D3,
   output logic [3:0] D4,
   output logic [2:0] COUNT,
   output logic       FULL,
   output logic       PIN_READY,
   output logic       ENTRY_ERR,
   output logic       TIMEOUT
);

   localparam int unsigned DIGITS    = 4;
   localparam logic [3:0]  EMPTY     = 4'hF;
   localparam logic [3:0]  KEY_CLEAR = 4'd10;
   localparam logic [3:0]  KEY_ENTER = 4'd11;

   typedef enum logic {
      ST_ENTRY = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   state_t     r_state;
   logic       r_kv_q;
   logic [3:0] r_digit [DIGITS];
   logic [2:0] r_count;
   logic       r_full;
   logic       r_pin_ready;
   logic       r_entry_err;
   logic       r_timeout;

   logic w_event;
   logic w_is_digit;
   logic w_is_clear;
   logic w_is_enter;

   // One event per key press: rising edge of KEY_VALID against its registered copy
   assign w_event    = KEY_VALID & ~r_kv_q;
   assign w_is_digit = (KEY_CODE <= 4'd9);
   assign w_is_clear = (KEY_CODE == KEY_CLEAR);
   assign w_is_enter = (KEY_CODE == KEY_ENTER);

`ifdef PIN_ENTRY_TIMEOUT_EN
   logic [23:0] r_idle;
   logic        w_idle_expired;

   assign w_idle_expired = (r_idle == (TIMEOUT_CYCLES - 24'd1));
`else
   logic w_unused_timeout_cycles;

   assign w_unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

   // Entry/done state machine with all outputs registered
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= ST_ENTRY;
         r_kv_q      <= 1'b0;
         for (int i = 0; i < DIGITS; i++) r_digit[i] <= EMPTY;
         r_count     <= 3'd0;
         r_full      <= 1'b0;
         r_pin_ready <= 1'b0;
         r_entry_err <= 1'b0;
         r_timeout   <= 1'b0;
`ifdef PIN_ENTRY_TIMEOUT_EN
         r_idle      <= 24'd0;
`endif
      end else begin
         r_kv_q      <= KEY_VALID;
         r_pin_ready <= 1'b0;
         r_entry_err <= 1'b0;
         r_timeout   <= 1'b0;

         case (r_state)
            ST_ENTRY: begin
               if (w_event && w_is_digit) begin
                  // Digits past the fourth are dropped silently
                  if (r_count != 3'd4) begin
                     r_digit[r_count[1:0]] <= KEY_CODE;
                     r_count               <= r_count + 3'd1;
                     r_full                <= (r_count == 3'd3);
                  end
`ifdef PIN_ENTRY_TIMEOUT_EN
                  r_idle <= 24'd0;
`endif
               end else if (w_event && w_is_clear) begin
                  for (int i = 0; i < DIGITS; i++) r_digit[i] <= EMPTY;
                  r_count <= 3'd0;
                  r_full  <= 1'b0;
`ifdef PIN_ENTRY_TIMEOUT_EN
                  r_idle  <= 24'd0;
`endif
               end else if (w_event && w_is_enter) begin
                  if (r_full) begin
                     // Digits stay frozen for the comparator
                     r_state     <= ST_DONE;
                     r_pin_ready <= 1'b1;
                  end else begin
                     r_entry_err <= 1'b1;
                     for (int i = 0; i < DIGITS; i++) r_digit[i] <= EMPTY;
                     r_count     <= 3'd0;
                     r_full      <= 1'b0;
                  end
`ifdef PIN_ENTRY_TIMEOUT_EN
                  r_idle <= 24'd0;
`endif
               end
`ifdef PIN_ENTRY_TIMEOUT_EN
               // Idle only while digits are held; a key on the expiry edge wins
               else if (r_count != 3'd0) begin
                  if (w_idle_expired) begin
                     for (int i = 0; i < DIGITS; i++) r_digit[i] <= EMPTY;
                     r_count   <= 3'd0;
                     r_full    <= 1'b0;
                     r_timeout <= 1'b1;
                     r_idle    <= 24'd0;
                  end else begin
                     r_idle <= r_idle + 24'd1;
                  end
               end
`endif
            end

            ST_DONE: begin
               // ACK has priority; any key event in the same cycle is discarded
               if (ACK || (w_event && w_is_clear)) begin
                  for (int i = 0; i < DIGITS; i++) r_digit[i] <= EMPTY;
                  r_count <= 3'd0;
                  r_full  <= 1'b0;
                  r_state <= ST_ENTRY;
               end
`ifdef PIN_ENTRY_TIMEOUT_EN
               r_idle <= 24'd0;
`endif
            end

            default: begin
               r_state <= ST_ENTRY;
            end
         endcase
      end
   end

   assign D1        = r_digit[0];
   assign D2        = r_digit[1];
   assign D3        = r_digit[2];
   assign D4        = r_digit[3];
   assign COUNT     = r_count;
   assign FULL      = r_full;
   assign PIN_READY = r_pin_ready;
   assign ENTRY_ERR = r_entry_err;
   assign TIMEOUT   = r_timeout;

endmodule

// File: tb/tb_pin_entry_buffer.sv
// ---------------------------------------------------------------------------
// tb_pin_entry_buffer
//   Directed self-checking bench for pin_entry_buffer. Inputs change 1 ns
//   after the rising edge and outputs are sampled at the same point.
//   The inactivity section follows PIN_ENTRY_TIMEOUT_EN with TIMEOUT_CYCLES=8.
// ---------------------------------------------------------------------------
module tb_pin_entry_buffer;

   logic       CLK = 1'b0;
   logic       RST;
   logic       KEY_VALID;
   logic [3:0] KEY_CODE;
   logic       ACK;
   logic [3:0] D1, D2, D3, D4;
   logic [2:0] COUNT;
   logic       FULL, PIN_READY, ENTRY_ERR, TIMEOUT;

   int n_checks   = 0;
   int n_failures = 0;

   // Pulses seen on the event edge and on the following release edge
   logic s_ready, s_err, s_to;
   logic s2_ready, s2_err, s2_to;
   logic to_seen;

   pin_entry_buffer #(.TIMEOUT_CYCLES(24'd8)) dut (
      .CLK(CLK), .RST(RST), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE),
      .ACK(ACK), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .COUNT(COUNT),
      .FULL(FULL), .PIN_READY(PIN_READY), .ENTRY_ERR(ENTRY_ERR),
      .TIMEOUT(TIMEOUT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [31:0] digits();
      return 32'({D1, D2, D3, D4});
   endfunction

   // One full key press: held for one edge, released for one edge
   task automatic press(input logic [3:0] code);
      KEY_VALID = 1'b1;
      KEY_CODE  = code;
      tick();
      s_ready = PIN_READY; s_err = ENTRY_ERR; s_to = TIMEOUT;
      KEY_VALID = 1'b0;
      tick();
      s2_ready = PIN_READY; s2_err = ENTRY_ERR; s2_to = TIMEOUT;
   endtask

   initial begin
      RST = 1'b1; KEY_VALID = 1'b0; KEY_CODE = 4'd0; ACK = 1'b0;
      tick(); tick();
      RST = 1'b0;
      tick();
      check("reset_digits", digits(), 32'hFFFF);
      check("reset_count", 32'(COUNT), 32'd0);
      check("reset_pulses", 32'({FULL, PIN_READY, ENTRY_ERR, TIMEOUT}), 32'd0);

      // Full PIN, fifth digit ignored, commit, DONE ignores digits, ACK clears
      press(4'd1); press(4'd2); press(4'd3);
      check("three_count", 32'(COUNT), 32'd3);
      check("three_full", 32'(FULL), 32'd0);
      press(4'd4);
      check("full_digits", digits(), 32'h1234);
      check("full_flag", 32'({FULL, COUNT}), 32'h0C);
      press(4'd7);
      check("fifth_digits", digits(), 32'h1234);
      check("fifth_no_err", 32'({s_err, s_ready}), 32'd0);
      press(4'd11);
      check("commit_pulse", 32'({s_ready, s_err}), 32'b10);
      check("commit_pulse_len", 32'(s2_ready), 32'd0);
      check("commit_hold", digits(), 32'h1234);
      press(4'd5);
      check("done_ignore_digit", digits(), 32'h1234);
      check("done_count", 32'(COUNT), 32'd4);
      press(4'd11);
      check("done_ignore_enter", 32'({s_ready, s_err, COUNT}), 32'd4);
      ACK = 1'b1; tick(); ACK = 1'b0;
      check("ack_digits", digits(), 32'hFFFF);
      check("ack_count_full", 32'({FULL, COUNT}), 32'd0);

      // Held key produces one digit
      KEY_VALID = 1'b1; KEY_CODE = 4'd5;
      repeat (20) tick();
      KEY_VALID = 1'b0; tick();
      check("held_count", 32'(COUNT), 32'd1);
      check("held_digits", digits(), 32'h5FFF);
      press(4'd10);
      check("clear_after_held", digits(), 32'hFFFF);

      // Ignored codes 12-15
      press(4'd2); press(4'd13);
      check("ignored_code", 32'({digits(), 1'b0, COUNT}), 32'h2FFF1);

      // Short PIN error and clear key
      press(4'd10);
      press(4'd9); press(4'd8);
      check("short_digits", digits(), 32'h98FF);
      press(4'd11);
      check("short_err_pulse", 32'({s_err, s_ready}), 32'b10);
      check("short_err_len", 32'(s2_err), 32'd0);
      check("short_cleared", 32'({digits(), 1'b0, COUNT}), 32'hFFFF0);
      press(4'd3);
      press(4'd10);
      check("clear_no_pulse", 32'({s_err, s_ready, s_to}), 32'd0);
      check("clear_digits", 32'({digits(), 1'b0, COUNT}), 32'hFFFF0);

      // ACK together with a digit event in DONE: ACK wins, digit dropped
      press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd11);
      KEY_VALID = 1'b1; KEY_CODE = 4'd6; ACK = 1'b1;
      tick();
      ACK = 1'b0; KEY_VALID = 1'b0;
      check("ack_key_digits", digits(), 32'hFFFF);
      check("ack_key_count", 32'(COUNT), 32'd0);
      tick();
      check("ack_key_dropped", 32'(COUNT), 32'd0);
      press(4'd2);
      check("entry_after_ack", 32'({digits(), 1'b0, COUNT}), 32'h2FFF1);
      press(4'd10);

`ifdef PIN_ENTRY_TIMEOUT_EN
      // Event edge e, auto-clear expected on edge e+8
      press(4'd6);
      repeat (6) tick();
      check("to_not_yet", 32'({TIMEOUT, COUNT}), 32'd1);
      tick();
      check("to_pulse", 32'(TIMEOUT), 32'd1);
      check("to_cleared", 32'({digits(), 1'b0, COUNT}), 32'hFFFF0);
      tick();
      check("to_pulse_len", 32'(TIMEOUT), 32'd0);
      // Key at idle cycle 7 restarts the count
      press(4'd6);
      repeat (5) tick();
      press(4'd7);
      check("to_restart_none", 32'({s_to, s2_to}), 32'd0);
      check("to_restart_digits", 32'({digits(), 1'b0, COUNT}), 32'h67FF2);
      repeat (6) tick();
      check("to_restart_hold", 32'({TIMEOUT, COUNT}), 32'd2);
      tick();
      check("to_restart_fire", 32'({TIMEOUT, digits()}), 32'h1FFFF);
`else
      press(4'd6);
      to_seen = 1'b0;
      repeat (100) begin
         tick();
         to_seen = to_seen | TIMEOUT;
      end
      check("no_to_pulse", 32'(to_seen), 32'd0);
      check("no_to_hold", 32'({digits(), 1'b0, COUNT}), 32'h6FFF1);
`endif
      press(4'd10);

      // Asynchronous reset mid-entry, observed before the next edge
      press(4'd1); press(4'd2);
      #2 RST = 1'b1;
      #1;
      check("async_rst_digits", digits(), 32'hFFFF);
      check("async_rst_state", 32'({FULL, PIN_READY, ENTRY_ERR, TIMEOUT, COUNT}), 32'd0);
      RST = 1'b0;
      tick();
      // Reset in DONE
      press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd11);
      #2 RST = 1'b1;
      #1;
      check("done_rst", 32'({digits(), FULL, COUNT}), 32'hFFFF0);
      RST = 1'b0;
      tick();
      press(4'd8);
      check("post_rst_entry", 32'({digits(), 1'b0, COUNT}), 32'h8FFF1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
